axil_bram_reader: RTL and testbench
===================================

# axil_bram_reader

AXI-Lite read master that copies a contiguous block of words from an AXI-Lite slave into a local BRAM write port. It sits on the FPGA side opposite a memory-mapped AXI-Lite slave. A single `start` pulse sweeps `word_count` sequential addresses with one read outstanding at a time, so it never overlaps reads and writes on the slave. It is used to pull PS-written coefficient tables or readback buffers into fabric RAM without CPU involvement.

## Interface
- `DATA_WIDTH`, 32, AXI-Lite and BRAM data width; multiple of 8.
- `AXI_ADDR_WIDTH`, 12, AXI byte-address width.
- `BRAM_ADDR_WIDTH`, 10, local BRAM word-address width.
- `TIMEOUT`, 1024, watchdog limit in cycles; used only with `AXIL_READER_TIMEOUT_EN`.
- `axi_clock`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  AXI_ADDR_WIDTH  first AXI byte address; low log2(DATA_WIDTH/8) bits ignored (forced 0).
- `word_count`  in  BRAM_ADDR_WIDTH+1  number of words, 0..2^BRAM_ADDR_WIDTH.
- `busy`  out  1  high from the accepted `start` until the `done` cycle, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  2  sticky status: [0] non-OKAY rresp, [1] timeout; cleared by an accepted `start`.
- `m_axil_araddr`  out  AXI_ADDR_WIDTH  read address.
- `m_axil_arprot`  out  3  constant 3'b000.
- `m_axil_arvalid`  out  1; `m_axil_arready`  in  1.
- `m_axil_rdata`  in  DATA_WIDTH; `m_axil_rresp`  in  2; `m_axil_rvalid`  in  1; `m_axil_rready`  out  1.
- `bram_addr`  out  BRAM_ADDR_WIDTH  local write address; `bram_din`  out  DATA_WIDTH; `bram_we`  out  1.

## Operation
- States: IDLE, AR, R, DONE.
- IDLE: when `start`=1:
  - latch `base_addr`, aligned, into the address register;
  - load the word counter from `word_count`;
  - clear `err`;
  - go to AR, or to DONE if `word_count`=0.
- AR: `arvalid`=1 with a stable `araddr` until `arvalid`&&`arready`, then go to R.
- R: `rready`=1 until `rvalid`&&`rready`. On that cycle:
  - register `rdata` into `bram_din` and assert `bram_we` on the next cycle at the current `bram_addr`;
  - advance `araddr` by DATA_WIDTH/8 (wraps modulo 2^AXI_ADDR_WIDTH);
  - decrement the counter;
  - go to DONE if the counter reaches 0, else to AR.
- `rresp`≠2'b00: set `err[0]`, still store the data, and abort to DONE after this word.
- `bram_addr` starts at 0 and increments after each BRAM write. At 2^BRAM_ADDR_WIDTH words it wraps to 0 only after the last write.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0; `araddr`=0, `bram_addr`=0, `err`=0; state IDLE.
- `arvalid` rises the cycle after `start`.
- Per word with zero-wait slave: 1 cycle AR + 1 cycle R = 2 cycles/word. Total from `start` to `done` is 2·N+1 cycles.
- `bram_we` is a one-cycle pulse, one cycle after each R handshake. The last `bram_we` coincides with the `done` cycle.
- `arvalid` never deasserts before `arready`, except on timeout. `rready` is high only in R.
- `arvalid` and `rready` are never high in the same cycle: one outstanding read.
- Reset mid-transfer: immediate return to IDLE, all outputs to reset values, no `done`.

## Configuration
- `AXIL_READER_TIMEOUT_EN` defined:
  - a counter runs in AR and R and clears on each handshake;
  - reaching `TIMEOUT` cycles sets `err[1]`, drops `arvalid`/`rready`, and goes to DONE;
  - no further BRAM write occurs for the aborted word.
- Undefined: no counter; the block waits indefinitely for the slave.

## Test plan
- `base_addr`=0x100, `word_count`=4, zero-wait slave returning addr^0xA5A5A5A5:
  - required: `araddr` 0x100, 0x104, 0x108, 0x10C;
  - BRAM addresses 0..3 written with the matching data;
  - `done` 9 cycles after `start`; `err`=0.
- `word_count`=0: `done` the cycle after IDLE exits; no `arvalid`, no `bram_we`.
- Randomised `arready`/`rvalid` stalls of 0–7 cycles, 64 words:
  - required: AR payload stable while stalled;
  - all 64 words correct, no overlapping AR/R.
- Slave returns SLVERR on word 2 of 5: `err`=2'b01; words 0–2 written; `done` after the third R handshake.
- With `AXIL_READER_TIMEOUT_EN` and `TIMEOUT`=16, slave never asserts `arready`: `arvalid` drops after 16 cycles; `err`=2'b10; `done` pulses; no `bram_we`.
- `rst_n` low during word 3 of 8: all outputs 0 immediately, no `done`. A new `start` then completes normally with `err` cleared.

Source files
------------

// File: rtl/axil_bram_reader_if.sv
// AXI-Lite read-channel bundle (AR + R) shared by the block copy master and its slave.
interface axil_bram_reader_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 12
);
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_bram_reader.sv
// AXI-Lite read master that copies word_count sequential words from an
// AXI-Lite slave into a local BRAM write port, one read outstanding at a time.
// Optional watchdog: define AXIL_READER_TIMEOUT_EN to abort a stalled AR/R
// phase after TIMEOUT cycles (err[1]); without it the block waits forever.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; outputs quiet, status held
// S_AR   | arvalid high with a stable araddr until arready
// S_R    | rready high until rvalid; data captured for the BRAM write
// S_DONE | one-cycle done pulse (last bram_we lands here), then idle
module axil_bram_reader #(
  parameter int DATA_WIDTH      = 32,
  parameter int AXI_ADDR_WIDTH  = 12,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int TIMEOUT         = 1024
) (
  input  logic                       i_axi_clock,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [AXI_ADDR_WIDTH-1:0]  i_base_addr,
  input  logic [BRAM_ADDR_WIDTH:0]   i_word_count,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [1:0]                 o_err,
  axil_bram_reader_if.master         m_axil,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0]      o_bram_din,
  output logic                       o_bram_we
);

  localparam int WCW = BRAM_ADDR_WIDTH + 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP       = AXI_ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'((DATA_WIDTH / 8) - 1);

  // The watchdog must be able to count at least one stalled cycle.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                     r_state;
  logic [AXI_ADDR_WIDTH-1:0]  r_araddr;
  logic                       r_arvalid;
  logic                       r_rready;
  logic [WCW-1:0]             r_words;
  logic                       r_busy;
  logic                       r_done;
  logic [1:0]                 r_err;
  logic [BRAM_ADDR_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0]      r_bram_din;
  logic                       r_bram_we;
  logic                       w_rresp_bad;
  logic                       w_last_word;

`ifdef AXIL_READER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] r_to_cnt;
`endif

  assign w_rresp_bad = (m_axil.rresp != 2'b00);
  assign w_last_word = (r_words == WCW'(1));

  assign m_axil.araddr  = r_araddr;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = r_arvalid;
  assign m_axil.rready  = r_rready;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_bram_addr = r_bram_addr;
  assign o_bram_din  = r_bram_din;
  assign o_bram_we   = r_bram_we;

  // Sequencer: state, handshake outputs, address/word counters and status.
  always_ff @(posedge i_axi_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_words     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 2'b00;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_bram_we   <= 1'b0;
`ifdef AXIL_READER_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_bram_we <= 1'b0;
      // The write address moves on only after the word has been written,
      // so a full 2^BRAM_ADDR_WIDTH sweep wraps back to 0 after the last write.
      if (r_bram_we) begin
        r_bram_addr <= r_bram_addr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_araddr    <= i_base_addr & ~ALIGN_MASK;
            r_words     <= i_word_count;
            r_err       <= 2'b00;
            r_bram_addr <= '0;
            r_busy      <= 1'b1;
`ifdef AXIL_READER_TIMEOUT_EN
            r_to_cnt    <= TO_LOAD;
`endif
            if (i_word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
        end

        S_AR: begin
          if (m_axil.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
`ifdef AXIL_READER_TIMEOUT_EN
            r_to_cnt  <= TO_LOAD;
`endif
          end
`ifdef AXIL_READER_TIMEOUT_EN
          else if (r_to_cnt == '0) begin
            r_arvalid <= 1'b0;
            r_err[1]  <= 1'b1;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
`endif
        end

        S_R: begin
          if (m_axil.rvalid) begin
            r_rready   <= 1'b0;
            r_bram_din <= m_axil.rdata;
            r_bram_we  <= 1'b1;
            r_araddr   <= r_araddr + STEP;
            r_words    <= r_words - 1'b1;
`ifdef AXIL_READER_TIMEOUT_EN
            r_to_cnt   <= TO_LOAD;
`endif
            if (w_rresp_bad) begin
              r_err[0] <= 1'b1;
            end
            // An error response still stores its word but ends the sweep.
            if (w_rresp_bad || w_last_word) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
`ifdef AXIL_READER_TIMEOUT_EN
          else if (r_to_cnt == '0) begin
            r_rready <= 1'b0;
            r_err[1] <= 1'b1;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
`endif
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bram_reader.sv
// Scoreboard bench for axil_bram_reader: a reactive AXI-Lite slave with random
// stalls, a reference model that expands each job into expected AR addresses,
// BRAM writes and final status, and a negedge monitor that checks them.
module tb_axil_bram_reader;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int BW    = 10;
  localparam int TMO   = 16;
  localparam int NOERR = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [BW:0]   word_count = '0;
  logic          busy, done, bram_we;
  logic [1:0]    err;
  logic [BW-1:0] bram_addr;
  logic [DW-1:0] bram_din;

  axil_bram_reader_if #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) axil ();

  axil_bram_reader #(
    .DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .BRAM_ADDR_WIDTH(BW), .TIMEOUT(TMO)
  ) dut (
    .i_axi_clock (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_word_count(word_count),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .m_axil      (axil),
    .o_bram_addr (bram_addr),
    .o_bram_din  (bram_din),
    .o_bram_we   (bram_we)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [AW-1:0]    araq[$];
  logic [BW+DW-1:0] wq[$];
  logic [1:0]       doneq[$];

  int  max_stall = 0;
  bit  never_ready = 1'b0;
  bit  ar_free = 1'b0;
  int  err_word = NOERR;
  int  word_idx = 0;
  int  stall = 0;
  int  s_st = 0;
  int  job_ar_cycles = 0;
  int  n_done = 0;
  int  done_cyc = 0;
  logic [AW-1:0] ar_hold = '0;
  bit  ar_hold_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = {{(DW-AW){1'b0}}, a} ^ 32'hA5A5_A5A5;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reactive slave: random stall before arready and before rvalid.
  initial begin
    axil.arready = 1'b0;
    axil.rvalid  = 1'b0;
    axil.rdata   = '0;
    axil.rresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        axil.arready = 1'b0;
        axil.rvalid  = 1'b0;
        s_st = 0;
        stall = 0;
      end else begin
        if (axil.arready) begin
          axil.arready = 1'b0;
          s_st = 1;
          stall = $urandom_range(max_stall, 0);
        end else if (axil.rvalid) begin
          axil.rvalid = 1'b0;
          s_st = 0;
          word_idx++;
          stall = $urandom_range(max_stall, 0);
        end
        if (s_st == 0) begin
          if (axil.arvalid && !never_ready) begin
            if (stall > 0) stall--;
            else begin
              axil.arready = 1'b1;
              axil.rdata   = slave_word(axil.araddr);
              axil.rresp   = (word_idx == err_word) ? 2'b10 : 2'b00;
            end
          end
        end else if (axil.rready && !axil.rvalid) begin
          if (stall > 0) stall--;
          else axil.rvalid = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents AR, a BRAM write or done.
  always @(negedge clk) begin
    if (!rst_n) begin
      ar_hold_v = 1'b0;
    end else begin
      if (axil.arvalid) begin
        job_ar_cycles++;
        if (ar_hold_v) check("ar_stable", axil.araddr, ar_hold);
        if (!ar_free && araq.size() == 0) flag("spurious_arvalid");
        if (axil.arready) begin
          if (araq.size() > 0) check("araddr", {axil.arprot, axil.araddr}, {3'b000, araq.pop_front()});
          ar_hold_v = 1'b0;
        end else begin
          ar_hold   = axil.araddr;
          ar_hold_v = 1'b1;
        end
      end else begin
        if (ar_hold_v && !ar_free) flag("arvalid_dropped");
        ar_hold_v = 1'b0;
      end
      if (axil.rvalid && axil.rready) check("no_overlap", axil.arvalid, 1'b0);
      if (bram_we) begin
        if (wq.size() == 0) flag("unexpected_bram_we");
        else check("bram_write", {bram_addr, bram_din}, wq.pop_front());
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (doneq.size() == 0) flag("unexpected_done");
        else check("done_err", err, doneq.pop_front());
        check("done_busy", busy, 1'b1);
        check("done_no_pending", wq.size() + araq.size(), 0);
      end
    end
  end

  task automatic wait_done(input int seen0, input int budget);
    int k;
    k = 0;
    while (n_done == seen0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_done == seen0) flag("done_timeout");
  endtask

  // Reference model: a job reads min(n, errw+1) words from consecutive aligned addresses.
  task automatic load_model(input logic [AW-1:0] base, input int n, input int errw);
    int nw;
    logic [AW-1:0] a;
    nw = (errw < n) ? errw + 1 : n;
    for (int i = 0; i < nw; i++) begin
      a = (base & ~AW'(3)) + AW'(4 * i);
      araq.push_back(a);
      wq.push_back({BW'(i), slave_word(a)});
    end
    doneq.push_back((errw < n) ? 2'b01 : 2'b00);
  endtask

  task automatic issue_start(input logic [AW-1:0] base, input int n, input int errw,
                             input int stall_max, output int c0);
    @(negedge clk);
    max_stall = stall_max;
    err_word  = errw;
    word_idx  = 0;
    stall     = $urandom_range(stall_max, 0);
    job_ar_cycles = 0;
    start      = 1'b1;
    base_addr  = base;
    word_count = (BW+1)'(n);
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input int n, input int errw,
                         input int stall_max, input bit chk_lat, input bit poke_start);
    int c0, seen0, nw;
    nw = (errw < n) ? errw + 1 : n;
    load_model(base, n, errw);
    seen0 = n_done;
    issue_start(base, n, errw, stall_max, c0);
    #1;
    check("busy_after_start", busy, 1'b1);
    if (poke_start) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      base_addr = AW'($urandom);
      word_count = 5;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(seen0, 50 + n * 2 * (stall_max + 2));
    if (chk_lat) check("done_latency", done_cyc - c0, 2 * nw + 1);
    @(negedge clk);
    #1;
    check("idle_after_done", {busy, done}, 2'b00);
  endtask

  task automatic reset_midjob();
    int c0, k;
    logic [AW-1:0] base;
    base = AW'($urandom);
    load_model(base, 8, NOERR);
    issue_start(base, 8, NOERR, 0, c0);
    k = 0;
    while (wq.size() > 5 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (wq.size() > 5) flag("reset_wait_timeout");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_outputs",
          {busy, done, err, axil.arvalid, axil.rready, axil.araddr, axil.arprot,
           bram_we, bram_addr, bram_din}, 64'h0);
    araq.delete();
    wq.delete();
    doneq.delete();
    k = n_done;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", n_done, k);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3 rst_n = 1'b0;
    #2;
    check("reset_state",
          {busy, done, err, axil.arvalid, axil.rready, axil.araddr, axil.arprot,
           bram_we, bram_addr, bram_din}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(12'h100, 4, NOERR, 0, 1'b1, 1'b0);
    run_job(AW'($urandom), 0, NOERR, 0, 1'b1, 1'b0);
    run_job(AW'($urandom), 64, NOERR, 7, 1'b0, 1'b1);
    run_job(12'h200, 5, 2, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 2'b01);
    run_job(AW'($urandom), 7, NOERR, 3, 1'b0, 1'b0);
    run_job(12'hF02, 1024, NOERR, 0, 1'b1, 1'b0);
    check("bram_addr_wrap", bram_addr, '0);
    run_job(12'h300, 8, 2, 5, 1'b0, 1'b0);
    reset_midjob();
    run_job(AW'($urandom), 6, NOERR, 0, 1'b1, 1'b0);

`ifdef AXIL_READER_TIMEOUT_EN
    begin
      int c0, seen0;
      ar_free = 1'b1;
      never_ready = 1'b1;
      doneq.push_back(2'b10);
      seen0 = n_done;
      issue_start(12'h040, 5, NOERR, 0, c0);
      wait_done(seen0, 100);
      check("timeout_ar_cycles", job_ar_cycles, TMO);
      @(negedge clk);
      never_ready = 1'b0;
      ar_free = 1'b0;
      run_job(12'h040, 3, NOERR, 2, 1'b0, 1'b0);
    end
`endif

    for (int j = 0; j < 4; j++) begin
      run_job(AW'($urandom), $urandom_range(20, 1), NOERR, $urandom_range(7, 0), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
